nibble_serial_subtractor: RTL and testbench

//   Multi-cycle WIDTH-bit subtractor: diff = a - b - bin, computed one 4-bit slice per clock.

---
 rtl/nibble_serial_subtractor.sv | 129 ++++++++++++
 tb/tb_nibble_serial_subtractor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_subtractor.sv
// Serial WIDTH-bit subtractor: diff = a - b - bin, one 4-bit CLA slice per clock (a + ~b, carry = ~borrow).
// Latency: out_valid rises N=WIDTH/4 edges after accept; in_ready only in IDLE, result held until out_ready.
module nibble_serial_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             ovf
);

    localparam int N  = WIDTH / 4;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    generate
        if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
            $error("nibble_serial_subtractor: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] nb_q, nb_d;
    logic             carry_q, carry_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;

    logic [3:0] sa, sb, p, g, sum;
    logic       c1, c2, c3, c4;

    // Carry-lookahead slice on the currently selected nibble
    always_comb begin
        sa  = a_q[{idx_q, 2'b00} +: 4];
        sb  = nb_q[{idx_q, 2'b00} +: 4];
        p   = sa ^ sb;
        g   = sa & sb;
        c1  = g[0] | (p[0] & carry_q);
        c2  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_q);
        c3  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        c4  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (&p & carry_q);
        sum = p ^ {c3, c2, c1, carry_q};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        nb_d     = nb_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    nb_d    = ~b;
                    carry_d = ~bin;
                    idx_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                diff_d[{idx_q, 2'b00} +: 4] = sum;
                carry_d = c4;
                idx_d   = idx_q + IW'(1);
                if (idx_q == IW'(N - 1)) begin
                    state_d  = DONE;
                    borrow_d = ~c4;
                    zero_d   = ~|diff_d;
                    // nb_q holds ~b, so its MSB is inverted back to recover b's sign
                    ovf_d    = (a_q[WIDTH-1] ^ ~nb_q[WIDTH-1]) & (a_q[WIDTH-1] ^ diff_d[WIDTH-1]);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            nb_q     <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            nb_q     <= nb_d;
            carry_q  <= carry_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign zero       = zero_q;
    assign ovf        = ovf_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Table-driven bench for the serial subtractor plus directed hold, ignore-input and reset sequences.
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow_out, zero, ovf;

    int compared   = 0;
    int mismatched = 0;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .borrow_out(borrow_out), .zero(zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        borrow;
        logic        zero;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Accept one operation, measure latency, check results, then drain it.
    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                          input logic [15:0] ed, input logic eb, input logic ez, input logic eo);
        int cnt;
        chk("in_ready_idle", in_ready, 1);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < 20) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", cnt, 4);
        chk("diff", diff, ed);
        chk("borrow_out", borrow_out, eb);
        chk("zero", zero, ez);
        chk("ovf", ovf, eo);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] full;
        int          sd;
        logic        eo;
        logic [15:0] held;

        vecs[0]  = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; bin = 1'b0;
        #17;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_zero", zero, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin,
                   vecs[i].diff, vecs[i].borrow, vecs[i].zero, vecs[i].ovf);

        // Back-pressure: hold in DONE, ignore in_valid during BUSY and DONE
        a = 16'h1111; b = 16'h0022; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'h0000; bin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("busy_in_ready", in_ready, 0);
            in_valid = (k % 2 == 0);
            @(posedge clk); #1;
        end
        chk("hold_valid_rise", out_valid, 1);
        chk("hold_diff", diff, 16'h10EF);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            @(posedge clk); #1;
            chk("hold_valid", out_valid, 1);
            chk("hold_diff_stable", diff, 16'h10EF);
            chk("hold_borrow", borrow_out, 0);
            chk("hold_in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", out_valid, 0);
        chk("release_in_ready", in_ready, 1);

        // Reset while idx=2 in BUSY: partial diff must be cleared and never flagged
        a = 16'hABCD; b = 16'h1234; bin = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_diff", diff, 0);
        chk("midrst_borrow", borrow_out, 0);
        chk("midrst_zero", zero, 0);
        chk("midrst_ovf", ovf, 0);
        #10;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("postrst_in_ready", in_ready, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("postrst_no_valid", out_valid, 0);
        end
        run_op(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

        // Random vectors against an arithmetic model
        for (int k = 0; k < 2000; k++) begin
            logic [15:0] ra, rb;
            logic        rbin;
            ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom_range(0, 1));
            full = {1'b0, ra} - {1'b0, rb} - {16'b0, rbin};
            sd   = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
            eo   = (sd > 32767) || (sd < -32768);
            held = full[15:0];
            run_op(ra, rb, rbin, held, full[16], held == 16'h0, eo);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
